// File: rtl/hazard_stall_control_pkg.sv
// rtl/hazard_stall_control_pkg.sv - shared types and constants for hazard/stall control
package hazard_stall_control_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;
    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    // XZR reads as zero and is never written, so it cannot carry a load result.
    function automatic logic load_use_hazard(
        input logic             mem_read,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rn,
        input logic [REG_W-1:0] rm
    );
        return mem_read && (rd != XZR) && ((rd == rn) || (rd == rm));
    endfunction

endpackage

// File: rtl/sat_counter_32.sv
// rtl/sat_counter_32.sv - event counter that sticks at all-ones
module sat_counter_32
    import hazard_stall_control_pkg::*;
(
    input  logic             clk,
    input  logic             Reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_control.sv
// rtl/hazard_stall_control.sv - pipeline stall/flush/freeze sequencer with event counters
module hazard_stall_control
    import hazard_stall_control_pkg::*;
(
    input  logic             clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] IFID_Rn,
    input  logic [REG_W-1:0] IFID_Rm,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rd,
    input  logic             EXMEM_BranchTaken,
    input  logic             MemBusy,
    output logic             PC_Stall,
    output logic             IFID_Stall,
    output logic             IDEX_Bubble,
    output logic             Flush_IF,
    output logic             Flush_ID,
    output logic             Flush_EX,
    output logic             Pipe_Freeze,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    state_t state, state_nxt;
    logic   load_use;
    logic   do_stall, do_bubble, do_flush, do_freeze;

    assign load_use = load_use_hazard(IDEX_MemRead, IDEX_Rd, IFID_Rn, IFID_Rm);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_RUN;
        do_stall  = 1'b0;
        do_bubble = 1'b0;
        do_flush  = 1'b0;
        do_freeze = 1'b0;
        case (state)
            ST_MEM_WAIT: begin
                // A branch seen during the wait is picked up once back in RUN.
                if (MemBusy) begin
                    do_stall  = 1'b1;
                    do_freeze = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                end
            end
            default: begin
                if (MemBusy) begin
                    do_stall  = 1'b1;
                    do_freeze = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                end else if (EXMEM_BranchTaken) begin
                    do_flush  = 1'b1;
                    state_nxt = ST_FLUSH;
                end else if (load_use && (state == ST_RUN)) begin
                    do_stall  = 1'b1;
                    do_bubble = 1'b1;
                    state_nxt = ST_LU_STALL;
                end
            end
        endcase
    end

    // Outputs are forced low for the whole time reset is held, not just at the edge.
    assign PC_Stall    = Reset & do_stall;
    assign IFID_Stall  = Reset & do_stall;
    assign IDEX_Bubble = Reset & do_bubble;
    assign Flush_IF    = Reset & do_flush;
    assign Flush_ID    = Reset & do_flush;
    assign Flush_EX    = Reset & do_flush;
    assign Pipe_Freeze = Reset & do_freeze;

    sat_counter_32 u_stall_cnt (
        .clk   (clk),
        .Reset (Reset),
        .inc   (PC_Stall),
        .count (Stall_Cnt)
    );

    sat_counter_32 u_flush_cnt (
        .clk   (clk),
        .Reset (Reset),
        .inc   (Flush_EX),
        .count (Flush_Cnt)
    );

endmodule

// File: tb/tb_hazard_stall_control.sv
// tb/tb_hazard_stall_control.sv - scoreboard bench for hazard_stall_control
module tb_hazard_stall_control;

    logic        clk;
    logic        Reset;
    logic [4:0]  IFID_Rn, IFID_Rm, IDEX_Rd;
    logic        IDEX_MemRead, EXMEM_BranchTaken, MemBusy;
    logic        PC_Stall, IFID_Stall, IDEX_Bubble;
    logic        Flush_IF, Flush_ID, Flush_EX, Pipe_Freeze;
    logic [31:0] Stall_Cnt, Flush_Cnt;

    hazard_stall_control dut (
        .clk               (clk),
        .Reset             (Reset),
        .IFID_Rn           (IFID_Rn),
        .IFID_Rm           (IFID_Rm),
        .IDEX_MemRead      (IDEX_MemRead),
        .IDEX_Rd           (IDEX_Rd),
        .EXMEM_BranchTaken (EXMEM_BranchTaken),
        .MemBusy           (MemBusy),
        .PC_Stall          (PC_Stall),
        .IFID_Stall        (IFID_Stall),
        .IDEX_Bubble       (IDEX_Bubble),
        .Flush_IF          (Flush_IF),
        .Flush_ID          (Flush_ID),
        .Flush_EX          (Flush_EX),
        .Pipe_Freeze       (Pipe_Freeze),
        .Stall_Cnt         (Stall_Cnt),
        .Flush_Cnt         (Flush_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PC_Stall, IFID_Stall, IDEX_Bubble, Flush_IF, Flush_ID, Flush_EX, Pipe_Freeze}
    localparam logic [6:0] C_NONE = 7'b000_0000;
    localparam logic [6:0] C_LU   = 7'b111_0000;
    localparam logic [6:0] C_FL   = 7'b000_1110;
    localparam logic [6:0] C_MW   = 7'b110_0001;

    logic [6:0] ctrl;
    assign ctrl = {PC_Stall, IFID_Stall, IDEX_Bubble, Flush_IF, Flush_ID, Flush_EX, Pipe_Freeze};

    typedef struct packed {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       br;
        logic       busy;
        logic [6:0] ctrl;
    } stim_t;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_stall, exp_flush;
    int          vectors, miscompares;

    function automatic stim_t st(input int mr, input int rd, input int rn, input int rm,
                                 input int br, input int busy, input logic [6:0] c);
        stim_t s;
        s.mr   = mr[0];
        s.rd   = rd[4:0];
        s.rn   = rn[4:0];
        s.rm   = rm[4:0];
        s.br   = br[0];
        s.busy = busy[0];
        s.ctrl = c;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        IDEX_MemRead      = s.mr;
        IDEX_Rd           = s.rd;
        IFID_Rn           = s.rn;
        IFID_Rm           = s.rm;
        EXMEM_BranchTaken = s.br;
        MemBusy           = s.busy;
        if (s.ctrl[6] && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
        if (s.ctrl[1] && exp_flush != 32'hFFFF_FFFF) exp_flush = exp_flush + 32'd1;
        sb.push_back({s.ctrl, exp_stall, exp_flush});
    endtask

    task automatic test_reset();
        @(negedge clk);
        Reset = 1'b0;
        drive(st(1, 3, 3, 3, 1, 1, C_NONE));
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        void'(sb.pop_front());
        #1;
        vectors++;
        if (ctrl !== C_NONE) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b exp %b", ctrl, C_NONE);
        end
        @(posedge clk); #1;
        vectors++;
        if (Stall_Cnt !== 32'd0 || Flush_Cnt !== 32'd0 || ctrl !== C_NONE) begin
            miscompares++;
            $display("FAIL reset_hold got ctrl=%b sc=%0d fc=%0d exp 0", ctrl, Stall_Cnt, Flush_Cnt);
        end
        @(negedge clk);
        Reset = 1'b1;
        drive(st(0, 0, 1, 2, 0, 0, C_NONE));
        #1;
        begin
            exp_t e = sb.pop_front();
            vectors++;
            if (ctrl !== e.ctrl) begin
                miscompares++;
                $display("FAIL reset_release got %b exp %b", ctrl, e.ctrl);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t t[$];
        exp_t  e;
        t.push_back(st(1, 3, 3, 0, 0, 0, C_LU));
        t.push_back(st(1, 3, 3, 0, 0, 0, C_NONE));
        t.push_back(st(1, 7, 1, 7, 0, 0, C_LU));
        t.push_back(st(0, 7, 1, 7, 0, 0, C_NONE));
        t.push_back(st(0, 7, 7, 7, 0, 0, C_NONE));
        foreach (t[i]) begin
            @(negedge clk); drive(t[i]); #1;
            e = sb.pop_front();
            vectors++;
            if (ctrl !== e.ctrl) begin
                miscompares++;
                $display("FAIL load_use[%0d] ctrl got %b exp %b", i, ctrl, e.ctrl);
            end
            @(posedge clk); #1;
            vectors++;
            if (Stall_Cnt !== e.sc || Flush_Cnt !== e.fc) begin
                miscompares++;
                $display("FAIL load_use[%0d] cnt got %0d/%0d exp %0d/%0d", i, Stall_Cnt, Flush_Cnt, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_xzr();
        stim_t t[$];
        exp_t  e;
        t.push_back(st(1, 31, 0, 31, 0, 0, C_NONE));
        t.push_back(st(1, 31, 0, 31, 0, 0, C_NONE));
        t.push_back(st(1, 31, 31, 31, 0, 0, C_NONE));
        foreach (t[i]) begin
            @(negedge clk); drive(t[i]); #1;
            e = sb.pop_front();
            vectors++;
            if (ctrl !== e.ctrl) begin
                miscompares++;
                $display("FAIL xzr[%0d] ctrl got %b exp %b", i, ctrl, e.ctrl);
            end
            @(posedge clk); #1;
            vectors++;
            if (Stall_Cnt !== e.sc || Flush_Cnt !== e.fc) begin
                miscompares++;
                $display("FAIL xzr[%0d] cnt got %0d/%0d exp %0d/%0d", i, Stall_Cnt, Flush_Cnt, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_branch_load_use();
        stim_t t[$];
        exp_t  e;
        t.push_back(st(1, 3, 3, 0, 1, 0, C_FL));
        t.push_back(st(1, 3, 3, 0, 0, 0, C_NONE));
        t.push_back(st(1, 3, 3, 0, 0, 0, C_LU));
        t.push_back(st(0, 0, 1, 2, 1, 0, C_FL));
        t.push_back(st(0, 0, 1, 2, 1, 0, C_FL));
        t.push_back(st(0, 0, 1, 2, 0, 0, C_NONE));
        foreach (t[i]) begin
            @(negedge clk); drive(t[i]); #1;
            e = sb.pop_front();
            vectors++;
            if (ctrl !== e.ctrl) begin
                miscompares++;
                $display("FAIL branch_lu[%0d] ctrl got %b exp %b", i, ctrl, e.ctrl);
            end
            @(posedge clk); #1;
            vectors++;
            if (Stall_Cnt !== e.sc || Flush_Cnt !== e.fc) begin
                miscompares++;
                $display("FAIL branch_lu[%0d] cnt got %0d/%0d exp %0d/%0d", i, Stall_Cnt, Flush_Cnt, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t t[$];
        exp_t  e;
        for (int k = 0; k < 4; k++) t.push_back(st(0, 0, 1, 2, 1, 1, C_MW));
        t.push_back(st(0, 0, 1, 2, 1, 0, C_NONE));
        t.push_back(st(0, 0, 1, 2, 1, 0, C_FL));
        t.push_back(st(0, 0, 1, 2, 0, 0, C_NONE));
        foreach (t[i]) begin
            @(negedge clk); drive(t[i]); #1;
            e = sb.pop_front();
            vectors++;
            if (ctrl !== e.ctrl) begin
                miscompares++;
                $display("FAIL mem_wait[%0d] ctrl got %b exp %b", i, ctrl, e.ctrl);
            end
            @(posedge clk); #1;
            vectors++;
            if (Stall_Cnt !== e.sc || Flush_Cnt !== e.fc) begin
                miscompares++;
                $display("FAIL mem_wait[%0d] cnt got %0d/%0d exp %0d/%0d", i, Stall_Cnt, Flush_Cnt, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        exp_t  e;
        t.push_back(st(1, 3, 3, 0, 0, 0, C_LU));
        t.push_back(st(1, 3, 3, 0, 0, 1, C_MW));
        t.push_back(st(1, 3, 3, 0, 0, 0, C_NONE));
        t.push_back(st(1, 3, 3, 0, 0, 0, C_LU));
        t.push_back(st(1, 3, 3, 0, 1, 0, C_FL));
        t.push_back(st(0, 0, 1, 2, 0, 1, C_MW));
        t.push_back(st(0, 0, 1, 2, 0, 0, C_NONE));
        t.push_back(st(0, 0, 1, 2, 0, 0, C_NONE));
        foreach (t[i]) begin
            @(negedge clk); drive(t[i]); #1;
            e = sb.pop_front();
            vectors++;
            if (ctrl !== e.ctrl) begin
                miscompares++;
                $display("FAIL back_to_back[%0d] ctrl got %b exp %b", i, ctrl, e.ctrl);
            end
            @(posedge clk); #1;
            vectors++;
            if (Stall_Cnt !== e.sc || Flush_Cnt !== e.fc) begin
                miscompares++;
                $display("FAIL back_to_back[%0d] cnt got %0d/%0d exp %0d/%0d", i, Stall_Cnt, Flush_Cnt, e.sc, e.fc);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        // Enter MEM_WAIT, then reset while the memory is still busy.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); drive(st(0, 0, 1, 2, 1, 1, C_MW)); #1;
            e = sb.pop_front();
            vectors++;
            if (ctrl !== e.ctrl) begin
                miscompares++;
                $display("FAIL rst_mw_pre[%0d] ctrl got %b exp %b", k, ctrl, e.ctrl);
            end
            @(posedge clk);
        end
        @(negedge clk); #2;
        Reset = 1'b0;
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        #1;
        vectors++;
        if (ctrl !== C_NONE || Stall_Cnt !== 32'd0 || Flush_Cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_mw_async got ctrl=%b sc=%0d fc=%0d exp 0", ctrl, Stall_Cnt, Flush_Cnt);
        end
        @(negedge clk);
        Reset = 1'b1;
        drive(st(0, 0, 1, 2, 0, 1, C_MW)); #1;
        e = sb.pop_front();
        vectors++;
        if (ctrl !== e.ctrl) begin
            miscompares++;
            $display("FAIL rst_mw_resume ctrl got %b exp %b", ctrl, e.ctrl);
        end
        @(posedge clk); #1;
        vectors++;
        if (Stall_Cnt !== e.sc) begin
            miscompares++;
            $display("FAIL rst_mw_resume cnt got %0d exp %0d", Stall_Cnt, e.sc);
        end
        @(negedge clk); drive(st(0, 0, 1, 2, 0, 0, C_NONE)); #1;
        e = sb.pop_front();
        @(posedge clk);
        // Enter LU_STALL, reset, and check RUN evaluates the held hazard afresh.
        @(negedge clk); drive(st(1, 4, 4, 0, 0, 0, C_LU)); #1;
        e = sb.pop_front();
        @(posedge clk);
        @(negedge clk); #2;
        Reset = 1'b0;
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        #1;
        vectors++;
        if (ctrl !== C_NONE || Stall_Cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_lu_async got ctrl=%b sc=%0d exp 0", ctrl, Stall_Cnt);
        end
        @(negedge clk);
        Reset = 1'b1;
        drive(st(1, 4, 4, 0, 0, 0, C_LU)); #1;
        e = sb.pop_front();
        vectors++;
        if (ctrl !== e.ctrl) begin
            miscompares++;
            $display("FAIL rst_lu_resume ctrl got %b exp %b", ctrl, e.ctrl);
        end
        @(posedge clk);
        @(negedge clk); drive(st(0, 0, 1, 2, 0, 0, C_NONE)); #1;
        e = sb.pop_front();
        @(posedge clk);
    endtask

    task automatic test_saturation();
        exp_t e;
        @(negedge clk);
        drive(st(0, 0, 1, 2, 0, 0, C_NONE));
        e = sb.pop_front();
        force dut.u_stall_cnt.count_q = 32'hFFFF_FFFD;
        #1;
        release dut.u_stall_cnt.count_q;
        exp_stall = 32'hFFFF_FFFD;
        #1;
        vectors++;
        if (Stall_Cnt !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL sat_preload got %h exp fffffffd", Stall_Cnt);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(st(0, 0, 1, 2, 0, 1, C_MW)); #1;
            e = sb.pop_front();
            @(posedge clk); #1;
            vectors++;
            if (Stall_Cnt !== e.sc) begin
                miscompares++;
                $display("FAIL sat[%0d] got %h exp %h", k, Stall_Cnt, e.sc);
            end
        end
        @(negedge clk); drive(st(0, 0, 1, 2, 0, 0, C_NONE)); #1;
        e = sb.pop_front();
        @(posedge clk); #1;
        vectors++;
        if (Stall_Cnt !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL sat_hold got %h exp ffffffff", Stall_Cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors           = 0;
        miscompares       = 0;
        exp_stall         = 32'd0;
        exp_flush         = 32'd0;
        Reset             = 1'b0;
        IFID_Rn           = 5'd0;
        IFID_Rm           = 5'd0;
        IDEX_Rd           = 5'd0;
        IDEX_MemRead      = 1'b0;
        EXMEM_BranchTaken = 1'b0;
        MemBusy           = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_load_use();
        test_xzr();
        test_branch_load_use();
        test_mem_wait();
        test_back_to_back();
        test_reset_mid_op();
        test_saturation();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
